// File: rtl/vga_text_pkg.sv
// Shared constants, state encoding and geometry helpers for the character-cell text buffer.
package vga_text_pkg;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;

  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_e;

  // Screen geometry is a function of the module parameters, so it is derived here on demand.
  function automatic int geom_cols(input int h_disp, input int font_w);
    return h_disp / font_w;
  endfunction

  function automatic int geom_rows(input int v_disp, input int font_h);
    return v_disp / font_h;
  endfunction

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_text_ram.sv
// Simple dual-port cell store: one write port, one read port with a registered, resettable output.
module vga_text_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address read and write in one cycle returns the old cell (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_text_buffer.sv
// Terminal-style text buffer: handshake character stream, hardware cursor, ring-rotated scrolling
// and sweep clears, with a logical (row, col) read port for the renderer.
module vga_text_buffer import vga_text_pkg::*; #(
  parameter int         H_DISP    = 1280,
  parameter int         V_DISP    = 1024,
  parameter int         FONT_W    = 8,
  parameter int         FONT_H    = 8,
  parameter int         CHAR_W    = 8,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            wr_valid,
  input  logic [CHAR_W-1:0]                               wr_char,
  output logic                                            wr_ready,
  input  logic                                            clr_req,
  input  logic [width_of(geom_rows(V_DISP, FONT_H))-1:0] rd_row,
  input  logic [width_of(geom_cols(H_DISP, FONT_W))-1:0] rd_col,
  output logic [CHAR_W-1:0]                               rd_char,
  output logic [width_of(geom_rows(V_DISP, FONT_H))-1:0] cursor_row,
  output logic [width_of(geom_cols(H_DISP, FONT_W))-1:0] cursor_col,
  output logic                                            busy
);

  localparam int COLS   = geom_cols(H_DISP, FONT_W);
  localparam int ROWS   = geom_rows(V_DISP, FONT_H);
  localparam int CELLS  = COLS * ROWS;
  localparam int COL_W  = width_of(COLS);
  localparam int ROW_W  = width_of(ROWS);
  localparam int ADDR_W = width_of(CELLS);
  localparam logic [CHAR_W-1:0] FILL = CHAR_W'(FILL_CHAR);

  state_e            state;
  logic [ADDR_W-1:0] sweep_addr, sweep_end;
  logic [ROW_W-1:0]  cur_row, top_row, top_next;
  logic [COL_W-1:0]  cur_col;
  logic              accept, is_lf, is_cr, is_bs, printable, adv_row;
  logic              we;
  logic [ADDR_W-1:0] waddr, raddr, cur_addr;
  logic [CHAR_W-1:0] wdata;

  // Logical row to physical row through the ring offset; compare-subtract keeps ROWS arbitrary.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] r,
                                                input logic [ROW_W-1:0] top);
    logic [ROW_W:0] s;
    s = {1'b0, r} + {1'b0, top};
    if (s >= (ROW_W+1)'(ROWS)) s = s - (ROW_W+1)'(ROWS);
    return s[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  assign busy      = (state != IDLE);
  assign wr_ready  = (state == IDLE) && !clr_req;
  assign accept    = wr_valid && wr_ready;
  assign is_lf     = (wr_char[7:0] == CH_LF);
  assign is_cr     = (wr_char[7:0] == CH_CR);
  assign is_bs     = (wr_char[7:0] == CH_BS);
  assign printable = !(is_lf || is_cr || is_bs);
  assign adv_row   = accept && (is_lf || (printable && cur_col == COL_W'(COLS-1)));
  assign top_next  = (top_row == ROW_W'(ROWS-1)) ? '0 : top_row + 1'b1;

  assign cur_addr   = cell_addr(phys_row(cur_row, top_row), cur_col);
  assign raddr      = cell_addr(phys_row(rd_row, top_row), rd_col);
  assign cursor_row = cur_row;
  assign cursor_col = cur_col;

  // Sweeps own the write port while busy; otherwise printable stream characters use it.
  always_comb begin
    we    = 1'b0;
    waddr = sweep_addr;
    wdata = FILL;
    if (state != IDLE) begin
      we = 1'b1;
    end else if (accept && printable) begin
      we    = 1'b1;
      waddr = cur_addr;
      wdata = wr_char;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLR_ALL;
      sweep_addr <= '0;
      sweep_end  <= ADDR_W'(CELLS-1);
      cur_row    <= '0;
      cur_col    <= '0;
      top_row    <= '0;
    end else if (clr_req) begin
      state      <= CLR_ALL;
      sweep_addr <= '0;
      sweep_end  <= ADDR_W'(CELLS-1);
      cur_row    <= '0;
      cur_col    <= '0;
      top_row    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_cr || adv_row)           cur_col <= '0;
            else if (is_bs && cur_col != '0) cur_col <= cur_col - 1'b1;
            else if (printable)             cur_col <= cur_col + 1'b1;
          end
          // Scrolling rotates the ring and wipes the old top, which becomes the new bottom.
          if (adv_row) begin
            if (cur_row == ROW_W'(ROWS-1)) begin
              top_row    <= top_next;
              state      <= CLR_ROW;
              sweep_addr <= cell_addr(top_row, '0);
              sweep_end  <= cell_addr(top_row, COL_W'(COLS-1));
            end else begin
              cur_row <= cur_row + 1'b1;
            end
          end
        end
        default: begin
          if (sweep_addr == sweep_end) state <= IDLE;
          else                         sweep_addr <= sweep_addr + 1'b1;
        end
      endcase
    end
  end

  vga_text_ram #(
    .DEPTH (CELLS),
    .ADDR_W(ADDR_W),
    .WIDTH (CHAR_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rd_char)
  );

endmodule

// File: tb/tb_vga_text_buffer.sv
// Randomised and directed stimulus against a logical-screen model; reads are scored through an expected queue.
module tb_vga_text_buffer;

  localparam int COLS  = 4;
  localparam int ROWS  = 4;
  localparam int ROW_W = 2;
  localparam int COL_W = 2;
  localparam logic [7:0] FILL = 8'h20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_valid;
  logic [7:0]       wr_char;
  logic             wr_ready;
  logic             clr_req;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic [7:0]       rd_char;
  logic [ROW_W-1:0] cursor_row;
  logic [COL_W-1:0] cursor_col;
  logic             busy;

  logic       rd_en    = 1'b0;
  logic       rd_vld_d = 1'b0;
  logic [7:0] exp_q[$];
  int         tag_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [7:0] model [ROWS][COLS];
  int         m_row, m_col;

  vga_text_buffer #(
    .H_DISP(32), .V_DISP(32), .FONT_W(8), .FONT_H(8), .CHAR_W(8), .FILL_CHAR(8'h20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
    .clr_req(clr_req), .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a logical screen whose rows physically shift on scroll.
  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = FILL;
    m_row = 0;
    m_col = 0;
  endfunction

  function automatic void model_newline();
    m_col = 0;
    if (m_row < ROWS-1) begin
      m_row++;
    end else begin
      for (int r = 0; r < ROWS-1; r++)
        for (int c = 0; c < COLS; c++) model[r][c] = model[r+1][c];
      for (int c = 0; c < COLS; c++) model[ROWS-1][c] = FILL;
    end
  endfunction

  function automatic void model_apply(input logic [7:0] ch);
    if (ch == 8'h0A) model_newline();
    else if (ch == 8'h0D) m_col = 0;
    else if (ch == 8'h08) begin
      if (m_col > 0) m_col--;
    end else begin
      model[m_row][m_col] = ch;
      if (m_col == COLS-1) model_newline();
      else m_col++;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: read data is presented one cycle after the address.
  always @(posedge clk) rd_vld_d <= rd_en;

  always @(negedge clk) begin
    if (rd_vld_d) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_underflow: got %0h with no expected entry", rd_char);
      end else begin
        logic [7:0] e;
        int t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (rd_char !== e) begin
          n_bad++;
          $display("FAIL rd_char(%0d,%0d): got %0h expected %0h", t / COLS, t % COLS, rd_char, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic check_cursor(input string name);
    check({name, "_row"}, 32'(cursor_row), 32'(m_row));
    check({name, "_col"}, 32'(cursor_col), 32'(m_col));
  endtask

  task automatic send_char(input logic [7:0] ch);
    int budget = 200;
    wr_valid = 1'b1;
    wr_char  = ch;
    while (!wr_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) check("ready_timeout", 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    model_apply(ch);
    check_cursor("cursor");
  endtask

  task automatic expect_busy(input string name, input int cycles);
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(n), 32'(cycles));
  endtask

  task automatic read_all();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        rd_row = ROW_W'(r);
        rd_col = COL_W'(c);
        rd_en  = 1'b1;
        exp_q.push_back(model[r][c]);
        tag_q.push_back(r * COLS + c);
        @(posedge clk); #1;
      end
    end
    rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_clear(input logic with_char);
    clr_req  = 1'b1;
    wr_valid = with_char;
    wr_char  = 8'h5A;
    #1;
    check("ready_during_clr", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    model_clear();
  endtask

  function automatic logic [7:0] rand_char();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 8'h0A;
    if (k == 1) return 8'h0D;
    if (k == 2) return 8'h08;
    return 8'($urandom_range(33, 126));
  endfunction

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_char = '0; clr_req = 1'b0; rd_row = '0; rd_col = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_ready", 32'(wr_ready), 32'd0);
    check("reset_rd_char", 32'(rd_char), 32'd0);
    check_cursor("reset_cursor");
    @(negedge clk);
    rst_n = 1'b1;
    expect_busy("reset_sweep_len", 16);
    check("ready_after_sweep", 32'(wr_ready), 32'd1);
    read_all();

    send_char(8'h41);
    send_char(8'h42);
    check("ab_cursor_col", 32'(cursor_col), 32'd2);
    read_all();

    do_clear(1'b1);
    check_cursor("clr_cursor");
    expect_busy("clr_sweep_len", 16);
    read_all();

    for (int i = 0; i < 4; i++) send_char(8'h30 + 8'(i));
    check("wrap_cursor_row", 32'(cursor_row), 32'd1);
    send_char(8'h0A);
    send_char(8'h0D);
    send_char(8'h08);
    check("ctrl_cursor_row", 32'(cursor_row), 32'd2);
    read_all();

    // Restart of a clear partway through an earlier clear
    do_clear(1'b0);
    repeat (5) @(posedge clk);
    #1;
    do_clear(1'b0);
    expect_busy("clr_restart_len", 16);

    for (int i = 0; i < 16; i++) send_char(8'h61 + 8'(i));
    expect_busy("scroll_busy_len", 4);
    check("scroll_cursor_row", 32'(cursor_row), 32'd3);
    read_all();

    for (int i = 0; i < 80; i++) begin
      send_char(rand_char());
      if (i % 20 == 19) begin
        expect_busy("rand_idle_wait", busy ? 4 : 0);
        read_all();
      end
    end

    do_clear(1'b0);
    expect_busy("pre_reset_clr", 16);
    for (int i = 0; i < 16; i++) send_char(8'h41 + 8'(i));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("midreset_busy", 32'(busy), 32'd1);
    check("midreset_ready", 32'(wr_ready), 32'd0);
    check("midreset_rd_char", 32'(rd_char), 32'd0);
    check_cursor("midreset_cursor");
    @(negedge clk);
    rst_n = 1'b1;
    expect_busy("midreset_sweep_len", 16);
    read_all();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
